// File: rtl/id_decode_pipe.sv
// MIPS instruction-decode stage: field decode, operand forwarding, load-use and
// HI/LO hazard stalls, and a valid/ready output register feeding EXE.
package mips_cpu_pkg;

    typedef enum logic [2:0] {
        ALUTYPE_NONE,
        ALUTYPE_ARITH,
        ALUTYPE_LOGIC,
        ALUTYPE_SHIFT,
        ALUTYPE_MULDIV,
        ALUTYPE_MOVE
    } alutype_e;

    typedef enum logic [4:0] {
        OP_NONE, OP_ADD, OP_SUB, OP_SLT, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_LUI,
        OP_SLL, OP_SRL, OP_SRA, OP_MULT, OP_DIV, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO
    } aluop_e;

    typedef struct packed {
        logic   sign;
        aluop_e op;
    } aluop_t;

    typedef enum logic [3:0] {
        MEM_NONE, MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_SB, MEM_SH, MEM_SW
    } memop_e;

    localparam logic [5:0] OPC_SPECIAL = 6'h00, OPC_ADDI = 6'h08, OPC_ADDIU = 6'h09,
                           OPC_SLTI = 6'h0A, OPC_SLTIU = 6'h0B, OPC_ANDI = 6'h0C,
                           OPC_ORI = 6'h0D, OPC_XORI = 6'h0E, OPC_LUI = 6'h0F,
                           OPC_LB = 6'h20, OPC_LH = 6'h21, OPC_LW = 6'h23,
                           OPC_LBU = 6'h24, OPC_LHU = 6'h25, OPC_SB = 6'h28,
                           OPC_SH = 6'h29, OPC_SW = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03,
                           FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07,
                           FN_MFHI = 6'h10, FN_MTHI = 6'h11, FN_MFLO = 6'h12,
                           FN_MTLO = 6'h13, FN_MULT = 6'h18, FN_MULTU = 6'h19,
                           FN_DIV = 6'h1A, FN_DIVU = 6'h1B, FN_ADD = 6'h20,
                           FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23,
                           FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26,
                           FN_NOR = 6'h27, FN_SLT = 6'h2A, FN_SLTU = 6'h2B;

endpackage

module id_decode_pipe
    import mips_cpu_pkg::*;
#(
    parameter bit BYTE_SWAP  = 1'b1,
    parameter bit FWD_EN     = 1'b1,
    parameter int MULDIV_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    output logic [4:0]  rfra1,
    output logic [4:0]  rfra2,
    input  logic [31:0] rfrd1,
    input  logic [31:0] rfrd2,
    input  logic        exe_we,
    input  logic [4:0]  exe_wa,
    input  logic [31:0] exe_wd,
    input  logic        exe_load,
    input  logic        mem_we,
    input  logic [4:0]  mem_wa,
    input  logic [31:0] mem_wd,
    output logic        out_valid,
    input  logic        out_ready,
    output alutype_e    out_alutype,
    output aluop_t      out_aluop,
    output memop_e      out_memop,
    output logic        out_rfwe,
    output logic        out_hilowe,
    output logic        out_dm2rf,
    output logic [4:0]  out_rfwa,
    output logic [31:0] out_src1,
    output logic [31:0] out_src2,
    output logic [31:0] out_dmdin,
    output logic        out_illegal
);

    typedef enum logic [1:0] {SRC2_RT, SRC2_SEXT, SRC2_ZEXT, SRC2_LUI} src2_sel_e;

    typedef struct packed {
        alutype_e  alutype;
        aluop_t    aluop;
        memop_e    memop;
        src2_sel_e src2_sel;
        logic      rfwe;
        logic      hilowe;
        logic      dm2rf;
        logic      illegal;
        logic      use_rd;
        logic      src1_sa;
        logic      reads_rs;
        logic      reads_rt;
        logic      muldiv;
        logic      hilo_move;
    } dec_t;

    logic [31:0] inst;
    logic [5:0]  opcode, func;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm;
    dec_t        dec;
    logic [31:0] fwd_rs, fwd_rt, src1, src2;
    logic [4:0]  rfwa;
    logic        load_use, hilo_stall, stall, accept;
    logic [4:0]  busy_cnt;

    assign inst   = BYTE_SWAP ? {in_inst[7:0], in_inst[15:8], in_inst[23:16], in_inst[31:24]}
                              : in_inst;
    assign opcode = inst[31:26];
    assign rs     = inst[25:21];
    assign rt     = inst[20:16];
    assign rd     = inst[15:11];
    assign sa     = inst[10:6];
    assign func   = inst[5:0];
    assign imm    = inst[15:0];
    assign rfra1  = rs;
    assign rfra2  = rt;

    // NOTE: every field gets a default before the case so no path can infer a latch.
    always_comb begin
        dec       = '0;
        dec.memop = MEM_NONE;
        if (opcode == OPC_SPECIAL) begin
            dec.use_rd = 1'b1;
            unique case (func)
                FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV: begin
                    dec.alutype  = ALUTYPE_SHIFT;
                    dec.aluop.op = (func[1:0] == 2'b00) ? OP_SLL :
                                   (func[1:0] == 2'b10) ? OP_SRL : OP_SRA;
                    dec.src1_sa  = !func[2];
                    dec.reads_rs = func[2];
                    dec.reads_rt = 1'b1;
                    dec.rfwe     = 1'b1;
                end
                FN_MFHI, FN_MFLO: begin
                    dec.alutype   = ALUTYPE_MOVE;
                    dec.aluop.op  = (func == FN_MFHI) ? OP_MFHI : OP_MFLO;
                    dec.rfwe      = 1'b1;
                    dec.hilo_move = 1'b1;
                end
                FN_MTHI, FN_MTLO: begin
                    dec.alutype   = ALUTYPE_MOVE;
                    dec.aluop.op  = (func == FN_MTHI) ? OP_MTHI : OP_MTLO;
                    dec.hilowe    = 1'b1;
                    dec.reads_rs  = 1'b1;
                    dec.hilo_move = 1'b1;
                end
                FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                    dec.alutype    = ALUTYPE_MULDIV;
                    dec.aluop.op   = func[1] ? OP_DIV : OP_MULT;
                    dec.aluop.sign = !func[0];
                    dec.hilowe     = 1'b1;
                    dec.reads_rs   = 1'b1;
                    dec.reads_rt   = 1'b1;
                    dec.muldiv     = 1'b1;
                end
                FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_SLT, FN_SLTU: begin
                    dec.alutype    = ALUTYPE_ARITH;
                    dec.aluop.op   = func[3] ? OP_SLT : (func[1] ? OP_SUB : OP_ADD);
                    dec.aluop.sign = !func[0];
                    dec.reads_rs   = 1'b1;
                    dec.reads_rt   = 1'b1;
                    dec.rfwe       = 1'b1;
                end
                FN_AND, FN_OR, FN_XOR, FN_NOR: begin
                    dec.alutype  = ALUTYPE_LOGIC;
                    dec.aluop.op = (func == FN_AND) ? OP_AND : (func == FN_OR) ? OP_OR :
                                   (func == FN_XOR) ? OP_XOR : OP_NOR;
                    dec.reads_rs = 1'b1;
                    dec.reads_rt = 1'b1;
                    dec.rfwe     = 1'b1;
                end
                default: dec.illegal = 1'b1;
            endcase
        end else begin
            unique case (opcode)
                OPC_ADDI, OPC_ADDIU, OPC_SLTI, OPC_SLTIU: begin
                    dec.alutype    = ALUTYPE_ARITH;
                    dec.aluop.op   = opcode[1] ? OP_SLT : OP_ADD;
                    dec.aluop.sign = !opcode[0];
                    dec.src2_sel   = SRC2_SEXT;
                    dec.reads_rs   = 1'b1;
                    dec.rfwe       = 1'b1;
                end
                OPC_ANDI, OPC_ORI, OPC_XORI: begin
                    dec.alutype  = ALUTYPE_LOGIC;
                    dec.aluop.op = (opcode == OPC_ANDI) ? OP_AND :
                                   (opcode == OPC_ORI)  ? OP_OR : OP_XOR;
                    dec.src2_sel = SRC2_ZEXT;
                    dec.reads_rs = 1'b1;
                    dec.rfwe     = 1'b1;
                end
                OPC_LUI: begin
                    dec.alutype  = ALUTYPE_LOGIC;
                    dec.aluop.op = OP_LUI;
                    dec.src2_sel = SRC2_LUI;
                    dec.rfwe     = 1'b1;
                end
                OPC_LB, OPC_LH, OPC_LW, OPC_LBU, OPC_LHU: begin
                    dec.alutype    = ALUTYPE_ARITH;
                    dec.aluop.op   = OP_ADD;
                    dec.aluop.sign = (opcode == OPC_LB) || (opcode == OPC_LH);
                    dec.memop      = (opcode == OPC_LB)  ? MEM_LB  : (opcode == OPC_LH)  ? MEM_LH :
                                     (opcode == OPC_LBU) ? MEM_LBU : (opcode == OPC_LHU) ? MEM_LHU :
                                     MEM_LW;
                    dec.src2_sel   = SRC2_SEXT;
                    dec.reads_rs   = 1'b1;
                    dec.rfwe       = 1'b1;
                    dec.dm2rf      = 1'b1;
                end
                OPC_SB, OPC_SH, OPC_SW: begin
                    dec.alutype  = ALUTYPE_ARITH;
                    dec.aluop.op = OP_ADD;
                    dec.memop    = (opcode == OPC_SB) ? MEM_SB : (opcode == OPC_SH) ? MEM_SH : MEM_SW;
                    dec.src2_sel = SRC2_SEXT;
                    dec.reads_rs = 1'b1;
                    dec.reads_rt = 1'b1;
                end
                default: dec.illegal = 1'b1;
            endcase
        end
    end

    function automatic logic [31:0] forward(input logic [4:0] addr, input logic [31:0] rf_data,
                                            input logic e_we, input logic [4:0] e_wa,
                                            input logic [31:0] e_wd, input logic m_we,
                                            input logic [4:0] m_wa, input logic [31:0] m_wd);
        if (addr == 5'd0)                         return 32'd0;
        if (FWD_EN && e_we && (e_wa == addr))     return e_wd;
        if (FWD_EN && m_we && (m_wa == addr))     return m_wd;
        return rf_data;
    endfunction

    always_comb begin
        fwd_rs = forward(rs, rfrd1, exe_we, exe_wa, exe_wd, mem_we, mem_wa, mem_wd);
        fwd_rt = forward(rt, rfrd2, exe_we, exe_wa, exe_wd, mem_we, mem_wa, mem_wd);
        src1   = dec.src1_sa ? {27'd0, sa} : fwd_rs;
        unique case (dec.src2_sel)
            SRC2_SEXT: src2 = {{16{imm[15]}}, imm};
            SRC2_ZEXT: src2 = {16'd0, imm};
            SRC2_LUI:  src2 = {imm, 16'd0};
            default:   src2 = fwd_rt;
        endcase
        rfwa = dec.use_rd ? rd : rt;
    end

    // A load still in EXE cannot be forwarded, so a dependent reader must wait a cycle.
    assign load_use   = exe_load && exe_we && (exe_wa != 5'd0) &&
                        ((dec.reads_rs && (exe_wa == rs)) || (dec.reads_rt && (exe_wa == rt)));
    assign hilo_stall = dec.hilo_move && (busy_cnt != 5'd0);
    assign stall      = in_valid && (load_use || hilo_stall);
    assign in_ready   = !rst && (!out_valid || out_ready) && !stall && !flush;
    assign accept     = in_valid && in_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt <= 5'd0;
        end else if (flush) begin
            busy_cnt <= busy_cnt;
        end else if (accept && dec.muldiv) begin
            busy_cnt <= 5'(MULDIV_LAT);
        end else if (busy_cnt != 5'd0) begin
            busy_cnt <= busy_cnt - 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_alutype <= ALUTYPE_NONE;
            out_aluop   <= '0;
            out_memop   <= MEM_NONE;
            out_rfwe    <= 1'b0;
            out_hilowe  <= 1'b0;
            out_dm2rf   <= 1'b0;
            out_rfwa    <= 5'd0;
            out_src1    <= 32'd0;
            out_src2    <= 32'd0;
            out_dmdin   <= 32'd0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_alutype <= dec.alutype;
            out_aluop   <= dec.aluop;
            out_memop   <= dec.illegal ? MEM_NONE : dec.memop;
            out_rfwe    <= dec.rfwe && !dec.illegal && (rfwa != 5'd0);
            out_hilowe  <= dec.hilowe && !dec.illegal;
            out_dm2rf   <= dec.dm2rf && !dec.illegal;
            out_rfwa    <= rfwa;
            out_src1    <= src1;
            out_src2    <= src2;
            out_dmdin   <= fwd_rt;
            out_illegal <= dec.illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_decode_pipe.sv
// Directed bench for id_decode_pipe: byte-swapped MIPS encodings with
// hand-computed operands, hazards, handshake holding, flush and reset.
module tb_id_decode_pipe;
    import mips_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [31:0] in_inst;
    logic [4:0]  rfra1, rfra2;
    logic [31:0] rfrd1, rfrd2;
    logic        exe_we, exe_load, mem_we;
    logic [4:0]  exe_wa, mem_wa;
    logic [31:0] exe_wd, mem_wd;
    logic        out_valid, out_ready;
    alutype_e    out_alutype;
    aluop_t      out_aluop;
    memop_e      out_memop;
    logic        out_rfwe, out_hilowe, out_dm2rf, out_illegal;
    logic [4:0]  out_rfwa;
    logic [31:0] out_src1, out_src2, out_dmdin;

    logic [31:0] rf [32];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_stall;

    always #5 clk = ~clk;

    assign rfrd1 = rf[rfra1];
    assign rfrd2 = rf[rfra2];

    id_decode_pipe dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .rfra1(rfra1), .rfra2(rfra2), .rfrd1(rfrd1), .rfrd2(rfrd2),
        .exe_we(exe_we), .exe_wa(exe_wa), .exe_wd(exe_wd), .exe_load(exe_load),
        .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd), .out_valid(out_valid),
        .out_ready(out_ready), .out_alutype(out_alutype), .out_aluop(out_aluop),
        .out_memop(out_memop), .out_rfwe(out_rfwe), .out_hilowe(out_hilowe),
        .out_dm2rf(out_dm2rf), .out_rfwa(out_rfwa), .out_src1(out_src1),
        .out_src2(out_src2), .out_dmdin(out_dmdin), .out_illegal(out_illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] swap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [31:0] r_inst(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sa,
                                           input logic [5:0] fn);
        return swap({6'h00, rs, rt, rd, sa, fn});
    endfunction

    function automatic logic [31:0] i_inst(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return swap({op, rs, rt, imm});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] inst);
        in_valid = 1'b1;
        in_inst  = inst;
    endtask

    // Counts cycles in_ready stays low for the presented instruction, bounded.
    task automatic count_stall(output int n);
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
        rf[0] = 32'hDEAD_BEEF;
        rf[1] = 32'd5;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        exe_we = 1'b0; exe_wa = 5'd0; exe_wd = 32'd0; exe_load = 1'b0;
        mem_we = 1'b0; mem_wa = 5'd0; mem_wd = 32'd0;
        issue(i_inst(6'h09, 5'd1, 5'd2, 16'hFFFF));

        // Reset state
        #2;
        check("rst_in_ready", in_ready, 0);
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_rfwe", out_rfwe, 0);
        check("rst_memop", 32'(out_memop), 32'(MEM_NONE));
        check("rst_src1", out_src1, 0);
        check("rst_illegal", out_illegal, 0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("post_rst_ready", in_ready, 1);

        // ADDIU r2,r1,-1
        issue(i_inst(6'h09, 5'd1, 5'd2, 16'hFFFF));
        tick();
        check("addiu_valid", out_valid, 1);
        check("addiu_src1", out_src1, 32'd5);
        check("addiu_src2", out_src2, 32'hFFFF_FFFF);
        check("addiu_rfwa", 32'(out_rfwa), 2);
        check("addiu_rfwe", out_rfwe, 1);
        check("addiu_sign", 32'(out_aluop.sign), 0);

        // ADD r4,r3,r0 with EXE and MEM both targeting r3: EXE wins, r0 reads 0
        exe_we = 1'b1; exe_wa = 5'd3; exe_wd = 32'hAA;
        mem_we = 1'b1; mem_wa = 5'd3; mem_wd = 32'hBB;
        issue(r_inst(5'd3, 5'd0, 5'd4, 5'd0, 6'h20));
        #1;
        check("add_ready", in_ready, 1);
        tick();
        check("add_valid_nobubble", out_valid, 1);
        check("add_src1_exe", out_src1, 32'hAA);
        check("add_src2_r0", out_src2, 32'd0);
        check("add_rfwa", 32'(out_rfwa), 4);

        // MEM-only forwarding on both operands
        exe_we = 1'b0;
        issue(r_inst(5'd3, 5'd3, 5'd4, 5'd0, 6'h20));
        tick();
        check("mem_fwd_src1", out_src1, 32'hBB);
        check("mem_fwd_src2", out_src2, 32'hBB);
        mem_we = 1'b0;

        // SLL r5,r6,7
        issue(r_inst(5'd0, 5'd6, 5'd5, 5'd7, 6'h00));
        tick();
        check("sll_src1_sa", out_src1, 32'd7);
        check("sll_src2_rt", out_src2, 32'h106);
        check("sll_alutype", 32'(out_alutype), 32'(ALUTYPE_SHIFT));

        // ORI r7,r1,0x8001 then LUI r8,0x1234
        issue(i_inst(6'h0D, 5'd1, 5'd7, 16'h8001));
        tick();
        check("ori_src2_zext", out_src2, 32'h0000_8001);
        check("ori_src1", out_src1, 32'd5);
        issue(i_inst(6'h0F, 5'd0, 5'd8, 16'h1234));
        tick();
        check("lui_src2", out_src2, 32'h1234_0000);
        check("lui_rfwa", 32'(out_rfwa), 8);

        // LBU r9,4(r1)
        issue(i_inst(6'h24, 5'd1, 5'd9, 16'h0004));
        tick();
        check("lbu_memop", 32'(out_memop), 32'(MEM_LBU));
        check("lbu_dm2rf", out_dm2rf, 1);
        check("lbu_sign", 32'(out_aluop.sign), 0);
        check("lbu_src2", out_src2, 32'd4);

        // Load-use: SW r5,0(r6) behind a load into r5
        exe_load = 1'b1; exe_we = 1'b1; exe_wa = 5'd5; exe_wd = 32'h55;
        issue(i_inst(6'h2B, 5'd6, 5'd5, 16'h0000));
        #1;
        check("lu_stall_ready", in_ready, 0);
        tick();
        check("lu_bubble_valid", out_valid, 0);
        exe_load = 1'b0; exe_wd = 32'h77;
        #1;
        check("lu_release_ready", in_ready, 1);
        tick();
        check("sw_valid", out_valid, 1);
        check("sw_dmdin_fwd", out_dmdin, 32'h77);
        check("sw_src1", out_src1, 32'h106);
        check("sw_memop", 32'(out_memop), 32'(MEM_SW));
        check("sw_rfwe", out_rfwe, 0);

        // Load pending on r5 but LUI r5 reads nothing: no stall
        exe_load = 1'b1;
        issue(i_inst(6'h0F, 5'd0, 5'd5, 16'h0001));
        #1;
        check("lu_noread_ready", in_ready, 1);
        tick();
        exe_load = 1'b0; exe_we = 1'b0;

        // MULT r1,r2 then MFLO r9
        issue(r_inst(5'd1, 5'd2, 5'd0, 5'd0, 6'h18));
        tick();
        check("mult_hilowe", out_hilowe, 1);
        check("mult_rfwe", out_rfwe, 0);
        check("mult_src2", out_src2, 32'h102);
        issue(r_inst(5'd0, 5'd0, 5'd9, 5'd0, 6'h12));
        #1;
        count_stall(n_stall);
        check("mflo_stall_cycles", n_stall, 4);
        tick();
        check("mflo_valid", out_valid, 1);
        check("mflo_rfwa", 32'(out_rfwa), 9);
        check("mflo_rfwe", out_rfwe, 1);

        // Backpressure: bundle held for 3 cycles
        out_ready = 1'b0;
        issue(i_inst(6'h08, 5'd1, 5'd10, 16'h0003));
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_ready", in_ready, 0);
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_rfwa", 32'(out_rfwa), 9);
            check("hold_op", 32'(out_aluop.op), 32'(OP_MFLO));
        end

        // Flush together with in_valid: instruction dropped
        out_ready = 1'b1; flush = 1'b1;
        #1;
        check("flush_ready", in_ready, 0);
        tick();
        check("flush_valid", out_valid, 0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check("flush_dropped", out_valid, 0);

        // Illegal opcode 3F, illegal R-type func 3F
        issue(swap({6'h3F, 26'h0}));
        tick();
        check("ill_op_valid", out_valid, 1);
        check("ill_op_flag", out_illegal, 1);
        check("ill_op_rfwe", out_rfwe, 0);
        check("ill_op_memop", 32'(out_memop), 32'(MEM_NONE));
        issue(r_inst(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F));
        tick();
        check("ill_fn_flag", out_illegal, 1);
        check("ill_fn_rfwe", out_rfwe, 0);

        // All-zero instruction is a NOP
        issue(32'h0);
        tick();
        check("nop_illegal", out_illegal, 0);
        check("nop_rfwe", out_rfwe, 0);
        check("nop_hilowe", out_hilowe, 0);

        // Flush must freeze the busy counter
        issue(r_inst(5'd1, 5'd2, 5'd0, 5'd0, 6'h18));
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        tick();
        flush = 1'b0;
        issue(r_inst(5'd0, 5'd0, 5'd9, 5'd0, 6'h12));
        #1;
        count_stall(n_stall);
        check("flush_keeps_busy", n_stall, 4);
        tick();

        // Reset during a stall discards the bundle and clears the counter
        issue(r_inst(5'd1, 5'd2, 5'd0, 5'd0, 6'h18));
        tick();
        out_ready = 1'b0;
        issue(r_inst(5'd0, 5'd0, 5'd9, 5'd0, 6'h12));
        #1;
        check("midstall_ready", in_ready, 0);
        tick();
        rst = 1'b1;
        tick();
        check("midstall_rst_valid", out_valid, 0);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        check("midstall_busy_clear", in_ready, 1);
        tick();
        check("midstall_mflo_valid", out_valid, 1);
        check("midstall_mflo_rfwa", 32'(out_rfwa), 9);
        in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
